// File: rtl/treasure_classifier.sv
// Per-frame red/blue pixel census split into three horizontal bands, followed by a
// colour/shape decision and a multi-frame confirmation of the 3-bit GPIO result.
`timescale 1ns/1ps
module treasure_classifier #(
  parameter int WIDTH          = 176,
  parameter int HEIGHT         = 144,
  parameter int MIN_PIXELS     = 400,
  parameter int CONFIRM_FRAMES = 2,
  parameter int R_MIN          = 5,
  parameter int B_MIN          = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PIXEL_IN,
  input  logic [9:0]  VGA_PIXEL_X,
  input  logic [9:0]  VGA_PIXEL_Y,
  output logic [2:0]  RESULT,
  output logic        RESULT_VALID,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT
);

  localparam logic [9:0]  W_LIM     = 10'(WIDTH);
  localparam logic [9:0]  H_LIM     = 10'(HEIGHT);
  localparam logic [9:0]  LAST_X    = 10'(WIDTH - 1);
  localparam logic [9:0]  LAST_Y    = 10'(HEIGHT - 1);
  localparam logic [9:0]  MID_START = 10'(HEIGHT / 3);
  localparam logic [9:0]  BOT_START = 10'(2 * HEIGHT / 3);
  localparam logic [14:0] MIN_PIX   = 15'(MIN_PIXELS);
  localparam logic [2:0]  CONFIRM   = 3'(CONFIRM_FRAMES);
  localparam logic [2:0]  RED_MIN   = 3'(R_MIN);
  localparam logic [1:0]  BLUE_MIN  = 2'(B_MIN);

  typedef enum logic [1:0] {SYNC, ACCUM, DECIDE, COMMIT} state_t;
  typedef enum logic [1:0] {BAND_TOP, BAND_MID, BAND_BOT} band_t;

  typedef struct packed {
    logic [14:0] total;
    logic [14:0] top;
    logic [14:0] mid;
    logic [14:0] bot;
  } census_t;

  function automatic logic [14:0] sat_inc(input logic [14:0] v, input logic en);
    return (en && !(&v)) ? v + 15'd1 : v;
  endfunction

  function automatic census_t tally(input census_t c, input logic hit, input band_t band);
    census_t n;
    n.total = sat_inc(c.total, hit);
    n.top   = sat_inc(c.top, hit && band == BAND_TOP);
    n.mid   = sat_inc(c.mid, hit && band == BAND_MID);
    n.bot   = sat_inc(c.bot, hit && band == BAND_BOT);
    return n;
  endfunction

  // Shape code from band distribution; 17-bit operands keep 2*T and 1.5*T exact.
  function automatic logic [1:0] shape_of(input census_t c);
    logic [16:0] t, m, b;
    t = {2'b00, c.top};
    m = {2'b00, c.mid};
    b = {2'b00, c.bot};
    if (b >= (t << 1))
      return 2'b01;
    else if (m >= t + (t >> 1) && m >= b + (b >> 1))
      return 2'b11;
    else
      return 2'b10;
  endfunction

  state_t      state;
  logic [9:0]  px, py;
  census_t     red_cnt, blue_cnt;
  census_t     red_next, blue_next;
  logic [2:0]  candidate, last_candidate, cand_next;
  logic [2:0]  confirm_cnt, confirm_next;
  logic [2:0]  pix_r, pix_g;
  logic [1:0]  pix_b;
  logic        is_red, is_blue, in_win, at_origin, at_last;
  band_t       band;

  assign {pix_r, pix_g, pix_b} = PIXEL_IN;
  assign is_red    = pix_r >= RED_MIN && pix_g <= 3'd2 && pix_b <= 2'd1;
  assign is_blue   = pix_b >= BLUE_MIN && pix_r <= 3'd2 && pix_g <= 3'd3;
  assign in_win    = px < W_LIM && py < H_LIM;
  assign at_origin = px == 10'd0 && py == 10'd0;
  assign at_last   = px == LAST_X && py == LAST_Y;

  // The origin pixel always opens a fresh census, whether leaving SYNC or restarting.
  assign red_next  = tally(at_origin ? '0 : red_cnt, is_red, band);
  assign blue_next = tally(at_origin ? '0 : blue_cnt, is_blue, band);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    band = BAND_BOT;
    if (py < MID_START)
      band = BAND_TOP;
    else if (py < BOT_START)
      band = BAND_MID;
  end

  always_comb begin
    cand_next = 3'b000;
    if (red_cnt.total >= MIN_PIX && red_cnt.total > blue_cnt.total)
      cand_next = {shape_of(red_cnt), 1'b1};
    else if (blue_cnt.total >= MIN_PIX && blue_cnt.total > red_cnt.total)
      cand_next = {shape_of(blue_cnt), 1'b0};
  end

  always_comb begin
    confirm_next = 3'd1;
    if (candidate == last_candidate)
      confirm_next = (confirm_cnt >= CONFIRM) ? CONFIRM : confirm_cnt + 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= SYNC;
      // NOTE: coordinates reset to an out-of-window value so a stale (0,0) cannot
      // open a frame on the first cycle after reset.
      px             <= '1;
      py             <= '1;
      red_cnt        <= '0;
      blue_cnt       <= '0;
      candidate      <= '0;
      last_candidate <= '0;
      confirm_cnt    <= '0;
      RESULT         <= '0;
      RESULT_VALID   <= 1'b0;
      RED_COUNT      <= '0;
      BLUE_COUNT     <= '0;
    end else begin
      px           <= VGA_PIXEL_X;
      py           <= VGA_PIXEL_Y;
      RESULT_VALID <= 1'b0;
      unique case (state)
        SYNC: begin
          if (at_origin) begin
            red_cnt  <= red_next;
            blue_cnt <= blue_next;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_win) begin
            red_cnt  <= red_next;
            blue_cnt <= blue_next;
          end
          if (at_last)
            state <= DECIDE;
        end
        DECIDE: begin
          candidate  <= cand_next;
          RED_COUNT  <= red_cnt.total;
          BLUE_COUNT <= blue_cnt.total;
          state      <= COMMIT;
        end
        COMMIT: begin
          confirm_cnt    <= confirm_next;
          last_candidate <= candidate;
          if (confirm_next >= CONFIRM)
            RESULT <= candidate;
          RESULT_VALID   <= 1'b1;
          red_cnt        <= '0;
          blue_cnt       <= '0;
          state          <= SYNC;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_treasure_classifier.sv
// Directed frames on a scaled 64x48 classifier scored through an expected-commit
// queue, with a concurrent 256x129 frame exercising count saturation.
`timescale 1ns/1ps
module tb_treasure_classifier;

  localparam int W    = 64;
  localparam int H    = 48;
  localparam int BAND = W * H / 3;
  localparam int SW   = 256;
  localparam int SH   = 129;
  localparam logic [7:0] PIX_RED   = 8'hE0;
  localparam logic [7:0] PIX_BLUE  = 8'h03;
  localparam logic [7:0] PIX_BLACK = 8'h00;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  PIXEL_IN;
  logic [9:0]  VGA_PIXEL_X, VGA_PIXEL_Y;
  logic [2:0]  RESULT;
  logic        RESULT_VALID;
  logic [14:0] RED_COUNT, BLUE_COUNT;

  logic        sat_rst;
  logic [7:0]  sat_pix;
  logic [9:0]  sat_x, sat_y;
  logic [2:0]  sat_result;
  logic        sat_valid;
  logic [14:0] sat_red, sat_blue;

  always #5 CLK = ~CLK;

  treasure_classifier #(.WIDTH(W), .HEIGHT(H)) u_dut (
    .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN),
    .VGA_PIXEL_X(VGA_PIXEL_X), .VGA_PIXEL_Y(VGA_PIXEL_Y),
    .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
    .RED_COUNT(RED_COUNT), .BLUE_COUNT(BLUE_COUNT)
  );

  treasure_classifier #(.WIDTH(SW), .HEIGHT(SH)) u_sat (
    .CLK(CLK), .RESET(sat_rst), .PIXEL_IN(sat_pix),
    .VGA_PIXEL_X(sat_x), .VGA_PIXEL_Y(sat_y),
    .RESULT(sat_result), .RESULT_VALID(sat_valid),
    .RED_COUNT(sat_red), .BLUE_COUNT(sat_blue)
  );

  typedef struct {
    logic [2:0]  result;
    logic [14:0] red;
    logic [14:0] blue;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         pat_r[3];
  int         pat_b[3];
  logic [7:0] pend_pix;
  logic [7:0] sat_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel data trails its coordinate by one cycle, as the registered buffer read does.
  task automatic step(input int x, input int y, input logic [7:0] pix);
    VGA_PIXEL_X = 10'(x);
    VGA_PIXEL_Y = 10'(y);
    PIXEL_IN    = pend_pix;
    pend_pix    = pix;
    @(posedge CLK);
    #1;
  endtask

  task automatic sat_step(input int x, input int y, input logic [7:0] pix);
    sat_x    = 10'(x);
    sat_y    = 10'(y);
    sat_pix  = sat_pend;
    sat_pend = pix;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pat(input int rt, input int rm, input int rb,
                         input int bt, input int bm, input int bb);
    pat_r[0] = rt; pat_r[1] = rm; pat_r[2] = rb;
    pat_b[0] = bt; pat_b[1] = bm; pat_b[2] = bb;
  endtask

  // Each band is filled row-major: red pixels first, then blue, then black.
  function automatic logic [7:0] pix_at(input int x, input int y);
    int band = y / (H / 3);
    int idx  = (y - band * (H / 3)) * W + x;
    if (idx < pat_r[band])
      return PIX_RED;
    if (idx < pat_r[band] + pat_b[band])
      return PIX_BLUE;
    return PIX_BLACK;
  endfunction

  task automatic blank_tail();
    for (int y = H; y < H + 3; y++)
      for (int x = 0; x < 16; x++)
        step(x * 50, y, PIX_RED);
    step(799, 524, PIX_RED);
    step(200, 150, PIX_RED);
  endtask

  task automatic run_frame(input logic [2:0] exp_res, input bit score = 1'b1,
                           input int abort_row = H, input int rst_x = -1,
                           input int rst_y = -1);
    int rsum = pat_r[0] + pat_r[1] + pat_r[2];
    int bsum = pat_b[0] + pat_b[1] + pat_b[2];
    if (score)
      sb.push_back('{exp_res, 15'(rsum), 15'(bsum)});
    for (int y = 0; y < abort_row; y++) begin
      for (int x = 0; x < W; x++) begin
        RESET = (x == rst_x && y == rst_y);
        step(x, y, pix_at(x, y));
        if (RESET) begin
          check("rst_mid_result", 32'(RESULT), 32'd0);
          check("rst_mid_valid", 32'(RESULT_VALID), 32'd0);
          check("rst_mid_red", 32'(RED_COUNT), 32'd0);
          check("rst_mid_blue", 32'(BLUE_COUNT), 32'd0);
          RESET = 1'b0;
        end
      end
      for (int k = 0; k < 7; k++)
        step(W + k * 100, y, PIX_RED);
    end
    if (abort_row == H)
      blank_tail();
  endtask

  task automatic sat_run();
    bit seen = 1'b0;
    for (int i = 0; i < 4; i++)
      sat_step(700, 500, PIX_RED);
    sat_rst = 1'b0;
    for (int i = 0; i < 4; i++)
      sat_step(700, 500, PIX_RED);
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        sat_step(x, y, PIX_RED);
    for (int i = 0; i < 12 && !seen; i++) begin
      sat_step(700, 500, PIX_RED);
      if (sat_valid === 1'b1) begin
        seen = 1'b1;
        check("sat_red_count", 32'(sat_red), 32'h7FFF);
        check("sat_blue_count", 32'(sat_blue), 32'd0);
        check("sat_result", 32'(sat_result), 32'd0);
      end
    end
    check("sat_commit_seen", 32'(seen), 32'd1);
  endtask

  // Every commit pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESULT_VALID === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0)
      else begin
        n_err++;
        $error("FAIL unexpected_valid: observed pulse at %0t expected none", $time);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", 32'(RESULT), 32'(e.result));
        check("red_count", 32'(RED_COUNT), 32'(e.red));
        check("blue_count", 32'(BLUE_COUNT), 32'(e.blue));
      end
    end
  end

  initial begin
    RESET       = 1'b1;
    VGA_PIXEL_X = 10'd700;
    VGA_PIXEL_Y = 10'd500;
    PIXEL_IN    = PIX_BLACK;
    pend_pix    = PIX_RED;
    sat_rst     = 1'b1;
    sat_x       = 10'd700;
    sat_y       = 10'd500;
    sat_pix     = PIX_BLACK;
    sat_pend    = PIX_RED;
    set_pat(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("reset_result", 32'(RESULT), 32'd0);
    check("reset_valid", 32'(RESULT_VALID), 32'd0);
    check("reset_red", 32'(RED_COUNT), 32'd0);
    check("reset_blue", 32'(BLUE_COUNT), 32'd0);
    RESET = 1'b0;
    fork
      sat_run();
    join_none
    for (int i = 0; i < 4; i++)
      step(700, 500, PIX_RED);

    set_pat(BAND, BAND, BAND, 0, 0, 0);     // all red: square
    run_frame(3'b000);
    run_frame(3'b101);
    run_frame(3'b101);

    set_pat(0, 0, 0, 0, 500, 1000);         // blue triangle
    run_frame(3'b101);
    run_frame(3'b010);

    set_pat(300, 1000, 300, 0, 0, 0);       // red diamond
    run_frame(3'b010);
    run_frame(3'b111);

    set_pat(0, 0, 0, 0, 0, 0);              // blank frames
    run_frame(3'b111);
    run_frame(3'b000);

    set_pat(300, 0, 0, 0, 0, 0);            // below detection floor
    run_frame(3'b000);
    set_pat(1000, 0, 0, 0, 1000, 0);        // colour tie
    run_frame(3'b000);

    set_pat(BAND, BAND, BAND, 0, 0, 0);
    run_frame(3'b000);
    run_frame(3'b101);
    run_frame(3'b000, 1'b0, H, W / 2, H / 2);
    run_frame(3'b000);
    run_frame(3'b000, 1'b0, 20);
    run_frame(3'b101);

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      step(700, 500, PIX_BLACK);
    check("queue_drained", 32'(sb.size()), 32'd0);
    wait fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
